// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
package instr_loader_pkg;

  // Length field is a 16-bit big-endian word count.
  localparam int LEN_W          = 16;
  // Instruction words are four bytes wide.
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    LAST   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_e;

  // Big-endian lane mapping: byte 0 of a word lands in bits [31:24],
  // byte 3 in bits [7:0]. Returns the LSB position of the lane.
  function automatic logic [4:0] byte_lane(input logic [BCNT_W-1:0] idx);
    return 5'd24 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles accepted bytes into big-endian 32-bit words.
// word_done/word_out are combinational so the loader can register the
// memory write on the same edge that accepts the last byte of a word.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [31:0]       word_out,
  output logic              word_done,
  output logic [BCNT_W-1:0] byte_cnt
);

  logic [31:0]       word_q;
  logic [BCNT_W-1:0] cnt_q;

  // Counter wraps 3->0 naturally; each accepted byte is written into its lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (byte_valid) begin
      word_q[byte_lane(cnt_q) +: 8] <= byte_in;
      cnt_q                         <= cnt_q + 1'b1;
    end
  end

  // Present the completed word including the byte being accepted now.
  always_comb begin
    word_out                       = word_q;
    word_out[byte_lane(cnt_q) +: 8] = byte_in;
  end

  assign word_done = byte_valid && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign byte_cnt  = cnt_q;

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: parses a 16-bit length, writes N words into
// instruction memory, then releases the CPU (or flags a rejected length).
// Handshake: a byte transfers on a rising edge where rxValid && rxReady;
// rxReady depends on state only and never on rxValid.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rxData,
  input  logic          rxValid,
  output logic          rxReady,
  output logic          imWrEn,
  output logic [31:0]   imWrAddr,
  output logic [31:0]   imWrData,
  output logic          cpuRun,
  output logic [15:0]   wordCount,
  output logic          error,
  output loader_state_e state_dbg
);

  loader_state_e     state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_field;
  logic              len_bad;
  logic              accept;
  logic              pk_valid;
  logic              restart;
  logic              word_done;
  logic              last_word;
  logic [31:0]       word_asm;
  logic [BCNT_W-1:0] byte_cnt;

  assign rxReady   = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept    = rxValid && rxReady;
  assign pk_valid  = accept && (state_q == DATA);
  assign len_field = {len_hi_q, rxData};
  assign len_bad   = (len_field == '0) || ({16'd0, len_field} > 32'(DEPTH_WORDS));
  // wordCount equals the index of the word currently being assembled.
  assign last_word = (wordCount == (len_q - 16'd1));
  assign state_dbg = state_q;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (pk_valid),
    .byte_in    (rxData),
    .word_out   (word_asm),
    .word_done  (word_done),
    .byte_cnt   (byte_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LEN_HI;
    else        state_q <= state_d;
  end

  // Next-state decode; start is only honoured from DONE or ERROR.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: if (accept) state_d = len_bad ? ERROR : DATA;
      DATA:   if (word_done && last_word) state_d = LAST;
      LAST:   state_d = DONE;
      DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          restart = 1'b1;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  // Length capture, registered memory write, counters and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_q  <= '0;
      len_q     <= '0;
      imWrEn    <= 1'b0;
      imWrAddr  <= '0;
      imWrData  <= '0;
      wordCount <= '0;
      cpuRun    <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (accept && (state_q == LEN_HI)) len_hi_q <= rxData;
      if (accept && (state_q == LEN_LO)) len_q    <= len_field;
      imWrEn <= word_done;
      if (word_done) begin
        imWrAddr  <= {14'd0, wordCount, 2'b00};
        imWrData  <= word_asm;
        wordCount <= wordCount + 16'd1;
      end else if (restart) begin
        wordCount <= '0;
      end
      cpuRun <= (state_d == DONE);
      error  <= (state_d == ERROR);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxValid = 1'b0;
  logic          rxReady;
  logic          imWrEn;
  logic [31:0]   imWrAddr;
  logic [31:0]   imWrData;
  logic          cpuRun;
  logic [15:0]   wordCount;
  logic          error;
  loader_state_e state_dbg;

  instr_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .imWrEn    (imWrEn),
    .imWrAddr  (imWrAddr),
    .imWrData  (imWrData),
    .cpuRun    (cpuRun),
    .wordCount (wordCount),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard: {address, data} of expected memory writes, in order.
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_wr_cycle = -10;
  logic prev_cpu = 1'b0;
  bit rand_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1ns after the edge; every write
  // strobe is matched against the scoreboard here.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cycle++;
    if (imWrEn === 1'b1) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", {imWrAddr, imWrData}, e);
      end
      check("addr_in_range", 64'(imWrAddr <= 32'((DEPTH - 1) * 4)), 64'd1);
      last_wr_cycle = cycle;
    end
    if (cpuRun === 1'b1 && prev_cpu === 1'b0)
      check("cpurun_after_last_write", 64'(cycle), 64'(last_wr_cycle + 1));
    prev_cpu = cpuRun;
  endtask

  // Offer one byte until it is accepted; in random mode rxValid toggles and
  // garbage is driven on idle cycles.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    for (int n = 0; n < 200; n++) begin
      if (rand_valid) rxValid = 1'($urandom_range(0, 1));
      else            rxValid = 1'b1;
      rxData = rxValid ? b : 8'($urandom);
      acc = rxValid && rxReady;
      tick();
      if (acc) return;
    end
    check("byte_accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic stop_stream();
    rxValid = 1'b0;
    rxData  = 8'h00;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 20; n++) begin
      if (cpuRun === 1'b1 || error === 1'b1) return;
      tick();
    end
    check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int c0;
    logic [31:0] w;

    // Reset.
    reset = 1'b0;
    repeat (2) tick();
    check("rst_cpurun", 64'(cpuRun), 64'd0);
    check("rst_wren", 64'(imWrEn), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wordcount", 64'(wordCount), 64'd0);
    check("rst_addr_data", {imWrAddr, imWrData}, 64'd0);
    check("rst_rxready", 64'(rxReady), 64'd1);
    reset = 1'b1;
    tick();

    // Two-word load with rxValid held; no stalls allowed.
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h8C090004});
    c0 = cycle;
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h20080005); send_word(32'h8C090004);
    stop_stream();
    check("no_stall_cycles", 64'(cycle - c0), 64'd10);
    wait_done();
    check("t1_cpurun", 64'(cpuRun), 64'd1);
    check("t1_wordcount", 64'(wordCount), 64'd2);
    check("t1_rxready", 64'(rxReady), 64'd0);
    check("t1_pending", 64'(exp_q.size()), 64'd0);

    // Start from DONE, then a one-word load of zero.
    pulse_start();
    check("restart_cpurun", 64'(cpuRun), 64'd0);
    check("restart_wordcount", 64'(wordCount), 64'd0);
    check("restart_rxready", 64'(rxReady), 64'd1);
    exp_q.push_back({32'h0, 32'h00000000});
    send_byte(8'h00); send_byte(8'h01); send_word(32'h00000000);
    stop_stream();
    wait_done();
    check("t2_cpurun", 64'(cpuRun), 64'd1);
    check("t2_wordcount", 64'(wordCount), 64'd1);

    // Zero length is rejected.
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    stop_stream();
    repeat (3) tick();
    check("len0_error", 64'(error), 64'd1);
    check("len0_cpurun", 64'(cpuRun), 64'd0);
    check("len0_rxready", 64'(rxReady), 64'd0);

    // Length one above capacity is rejected.
    pulse_start();
    check("err_restart_error", 64'(error), 64'd0);
    send_byte(8'h00); send_byte(8'h41);
    stop_stream();
    repeat (3) tick();
    check("len65_error", 64'(error), 64'd1);
    check("len65_cpurun", 64'(cpuRun), 64'd0);
    check("len65_rxready", 64'(rxReady), 64'd0);

    // Three-word load with random rxValid.
    pulse_start();
    rand_valid = 1'b1;
    exp_q.push_back({32'h0, 32'h11111111});
    exp_q.push_back({32'h4, 32'h22222222});
    exp_q.push_back({32'h8, 32'h33333333});
    send_byte(8'h00); send_byte(8'h03);
    send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
    stop_stream();
    rand_valid = 1'b0;
    wait_done();
    check("t4_wordcount", 64'(wordCount), 64'd3);
    check("t4_pending", 64'(exp_q.size()), 64'd0);

    // Start pulse in DATA must be ignored.
    pulse_start();
    exp_q.push_back({32'h0, 32'h01020304});
    exp_q.push_back({32'h4, 32'h05060708});
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    stop_stream();
    pulse_start();
    check("data_start_state", 64'(state_dbg), 64'(DATA));
    send_byte(8'h04); send_word(32'h05060708);
    stop_stream();
    wait_done();
    check("t5_wordcount", 64'(wordCount), 64'd2);
    check("t5_cpurun", 64'(cpuRun), 64'd1);

    // Reset after six payload bytes of a two-word load.
    pulse_start();
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'hCAFEF00D); send_byte(8'hAA); send_byte(8'hBB);
    stop_stream();
    reset = 1'b0;
    #1;
    check("midrst_wren", 64'(imWrEn), 64'd0);
    check("midrst_wordcount", 64'(wordCount), 64'd0);
    check("midrst_addr_data", {imWrAddr, imWrData}, 64'd0);
    check("midrst_flags", {62'd0, cpuRun, error}, 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(LEN_HI));
    tick();
    reset = 1'b1;
    tick();
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    send_byte(8'h00); send_byte(8'h01); send_word(32'hDEADBEEF);
    stop_stream();
    wait_done();
    check("t6_wordcount", 64'(wordCount), 64'd1);
    check("t6_pending", 64'(exp_q.size()), 64'd0);

    // Full-capacity load: 64 words, last address 252.
    pulse_start();
    send_byte(8'h00); send_byte(8'h40);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      exp_q.push_back({32'(i * 4), w});
      send_word(w);
    end
    stop_stream();
    wait_done();
    check("full_wordcount", 64'(wordCount), 64'(DEPTH));
    check("full_last_addr", 64'(imWrAddr), 64'((DEPTH - 1) * 4));
    check("full_error", 64'(error), 64'd0);
    check("full_pending", 64'(exp_q.size()), 64'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
